// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the register-file write port between
// the ALU result FIFO and the load unit, with a starvation guard.
// Ports:
//   clk, rst                  clock, sync active-high reset
//   alu_valid/ready/waddr/wdata  ALU result handshake (buffered)
//   ld_valid/ready/waddr/wdata   load data handshake (unbuffered)
//   rf_we/waddr/wdata, wb_sel    registered write-port outputs
//   alu_pending                  ALU FIFO occupancy
module wb_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_STARVE = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [ADDR_W-1:0]           alu_waddr,
  input  logic [DATA_W-1:0]           alu_wdata,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [ADDR_W-1:0]           ld_waddr,
  input  logic [DATA_W-1:0]           ld_wdata,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  output logic                        wb_sel,
  output logic [$clog2(FIFO_DEPTH):0] alu_pending
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(MAX_STARVE + 1);

  logic [ADDR_W-1:0] amem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] dmem_q [FIFO_DEPTH];

  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              sel_q, sel_d;

  logic nonempty;
  logic force_alu;
  logic enq;
  logic grant_alu;
  logic grant_ld;

  assign nonempty  = (count_q != '0);
  assign force_alu = (starve_q == SW'(MAX_STARVE)) && nonempty;

  // Readiness depends only on start-of-cycle state, never on valids.
  assign alu_ready = !rst && (count_q < CW'(FIFO_DEPTH));
  assign ld_ready  = !rst && !force_alu;

  assign enq       = alu_valid && alu_ready;
  assign grant_alu = !rst && (force_alu || (!ld_valid && nonempty));
  assign grant_ld  = !rst && !force_alu && ld_valid;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q + CW'(enq) - CW'(grant_alu);
    starve_d = starve_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    sel_d    = sel_q;

    if (enq) begin
      wptr_d = wptr_q + PW'(1);
    end

    unique case (1'b1)
      grant_alu: begin
        rptr_d  = rptr_q + PW'(1);
        we_d    = 1'b1;
        waddr_d = amem_q[rptr_q];
        wdata_d = dmem_q[rptr_q];
        sel_d   = 1'b0;
      end
      grant_ld: begin
        we_d    = 1'b1;
        waddr_d = ld_waddr;
        wdata_d = ld_wdata;
        sel_d   = 1'b1;
      end
      default: ;
    endcase

    // Count consecutive load wins only while an ALU entry is waiting.
    if (grant_alu || !nonempty) begin
      starve_d = '0;
    end else if (grant_ld && starve_q != SW'(MAX_STARVE)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      sel_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      sel_q    <= sel_d;
    end
  end

  // Storage needs no reset: entries are only read below count_q.
  always_ff @(posedge clk) begin
    if (enq) begin
      amem_q[wptr_q] <= alu_waddr;
      dmem_q[wptr_q] <= alu_wdata;
    end
  end

  assign rf_we       = we_q;
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = wdata_q;
  assign wb_sel      = sel_q;
  assign alu_pending = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model,
// per-cycle output compare, directed scenarios plus random traffic.
module tb_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int MAXS  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  alu_waddr;
  logic [15:0] alu_wdata;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_waddr;
  logic [15:0] ld_wdata;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        wb_sel;
  logic [1:0]  alu_pending;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_sel(wb_sel), .alu_pending(alu_pending)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of buffered ALU results, starvation count,
  // and the expected registered write-port values.
  typedef struct { logic [2:0] a; logic [15:0] d; } ent_t;
  ent_t        mq[$];
  int          m_starve = 0;
  logic        e_we = 0;
  logic        e_sel = 0;
  logic [2:0]  e_addr = 0;
  logic [15:0] e_data = 0;

  always @(posedge clk) begin
    int n;
    bit acc;
    bit frc;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_starve = 0;
      e_we = 0; e_sel = 0; e_addr = 0; e_data = 0;
    end else begin
      n   = mq.size();
      acc = alu_valid && (n < DEPTH);
      frc = (m_starve == MAXS) && (n != 0);
      e.a = alu_waddr;
      e.d = alu_wdata;
      if (frc || (!ld_valid && n != 0)) begin
        e_we = 1; e_sel = 0;
        e_addr = mq[0].a; e_data = mq[0].d;
        void'(mq.pop_front());
        m_starve = 0;
      end else if (ld_valid) begin
        e_we = 1; e_sel = 1;
        e_addr = ld_waddr; e_data = ld_wdata;
        if (n == 0) m_starve = 0;
        else if (m_starve < MAXS) m_starve = m_starve + 1;
      end else begin
        e_we = 0;
        m_starve = 0;
      end
      if (acc) mq.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rf_we", rf_we, e_we);
      chk("rf_waddr", rf_waddr, e_addr);
      chk("rf_wdata", rf_wdata, e_data);
      chk("wb_sel", wb_sel, e_sel);
      chk("alu_pending", alu_pending, mq.size());
      chk("alu_ready", alu_ready, !rst && mq.size() < DEPTH);
      chk("ld_ready", ld_ready,
          !rst && !(m_starve == MAXS && mq.size() != 0));
    end
  end

  task automatic step(input logic r, input logic av,
                      input logic [2:0] aa, input logic [15:0] ad,
                      input logic lv, input logic [2:0] la,
                      input logic [15:0] ldd,
                      output bit aacc, output bit lacc);
    @(negedge clk);
    #2;
    rst = r; alu_valid = av; alu_waddr = aa; alu_wdata = ad;
    ld_valid = lv; ld_waddr = la; ld_wdata = ldd;
    #1;
    aacc = av && alu_ready;
    lacc = lv && ld_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    bit a, l;
    step(r, 0, 0, 0, 0, 0, 0, a, l);
  endtask

  initial begin
    bit aa, la;
    int ai;
    int nl;
    bit done;
    bit lvh;
    logic [2:0] lah;
    logic [15:0] ldh;
    logic rr;
    logic [15:0] aw[$];

    rst = 1; alu_valid = 0; alu_waddr = 0; alu_wdata = 0;
    ld_valid = 0; ld_waddr = 0; ld_wdata = 0;

    idle(1);
    idle(1);
    chk_en = 1;
    idle(0);
    chk("idle_we", rf_we, 0);
    chk("idle_sel", wb_sel, 0);
    chk("idle_alu_ready", alu_ready, 1);
    chk("idle_ld_ready", ld_ready, 1);
    chk("idle_pending", alu_pending, 0);

    step(0, 1, 3'd3, 16'h0006, 0, 0, 0, aa, la);
    chk("alu_lat1_we", rf_we, 0);
    idle(0);
    chk("alu_we", rf_we, 1);
    chk("alu_addr", rf_waddr, 3);
    chk("alu_data", rf_wdata, 16'h0006);
    chk("alu_sel", wb_sel, 0);
    idle(0);
    chk("alu_one_cycle", rf_we, 0);

    step(0, 0, 0, 0, 1, 3'd5, 16'hAAAA, aa, la);
    chk("ld_we", rf_we, 1);
    chk("ld_addr", rf_waddr, 5);
    chk("ld_data", rf_wdata, 16'hAAAA);
    chk("ld_sel", wb_sel, 1);
    idle(0);

    ai = 1;
    for (int c = 0; c < 20; c++) begin
      step(0, ai <= 3, 3'(ai), 16'(ai), 1, 3'(c),
           16'h1000 + 16'(c), aa, la);
      if (aa) ai++;
      if (rf_we && !wb_sel) aw.push_back(rf_wdata);
      if (c == 1) chk("full_alu_ready", alu_ready, 0);
      if (c == 2) chk("third_rejected", aa, 0);
      if (c == 4) chk("force_ld_ready", ld_ready, 0);
      if (c == 5) begin
        chk("forced_data", rf_wdata, 16'h0001);
        chk("forced_sel", wb_sel, 0);
      end
      if (c == 6) chk("ld_resume_sel", wb_sel, 1);
    end
    chk("alu_count", aw.size(), 3);
    for (int i = 0; i < aw.size(); i++)
      chk("alu_order", aw[i], i + 1);
    idle(0);
    idle(0);

    for (int r = 0; r < 2; r++) begin
      step(0, 1, 3'd7, 16'h0077 + 16'(r), 1, 3'd1, 16'h2000, aa, la);
      nl = 0;
      done = 0;
      for (int c = 0; c < 10 && !done; c++) begin
        step(0, 0, 0, 0, 1, 3'(c), 16'h2100 + 16'(c), aa, la);
        if (rf_we && !wb_sel) done = 1;
        else if (rf_we && wb_sel) nl++;
      end
      chk("starve_done", done, 1);
      chk("starve_loads", nl, MAXS);
      for (int c = 0; c < 3; c++)
        step(0, 0, 0, 0, 1, 3'd2, 16'h2200, aa, la);
    end
    idle(0);

    step(0, 1, 3'd1, 16'hBEEF, 1, 3'd4, 16'h3000, aa, la);
    step(0, 1, 3'd2, 16'hCAFE, 1, 3'd4, 16'h3001, aa, la);
    chk("pre_rst_pending", alu_pending, 2);
    step(1, 1, 3'd3, 16'hDEAD, 1, 3'd4, 16'h3002, aa, la);
    chk("rst_we", rf_we, 0);
    chk("rst_pending", alu_pending, 0);
    for (int c = 0; c < 6; c++) begin
      idle(0);
      chk("no_stale_we", rf_we, 0);
    end

    lvh = 0; lah = 0; ldh = 0;
    for (int c = 0; c < 400; c++) begin
      rr = ($urandom % 64) == 0;
      if (!lvh) begin
        lvh = ($urandom % 4) != 0;
        lah = 3'($urandom);
        ldh = 16'($urandom);
      end
      step(rr, 1'($urandom % 2), 3'($urandom), 16'($urandom),
           lvh, lah, ldh, aa, la);
      if (la) lvh = 0;
    end
    idle(0);
    idle(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
